// File: rtl/seq_state_pkg.sv
// State-code definitions shared by the sequencer and the consuming decoder.
// Legal codes are 0..3; anything at or above ILLEGAL_MIN is unencoded.
package seq_state_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        STOP  = 3'd3
    } state_t;

    localparam logic [2:0] ILLEGAL_MIN = 3'd4;

    function automatic logic even_par(input logic [2:0] c);
        return ^c;
    endfunction

endpackage

// File: rtl/state_code_sequencer_run_timer.sv
// RUN-phase cycle counter with clear, enable and freeze controls.
// tc flags the last RUN cycle (count == RUN_CYCLES-1).
module run_timer #(
    parameter int RUN_CYCLES = 8,
    parameter int CNT_W      = $clog2(RUN_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             frz,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_CYCLES - 1);

    assign tc = (cnt == LAST);

    // Count up while running; hold at the terminal value or when frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !frz && !tc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/state_code_sequencer.sv
// IDLE/START/RUN/STOP state-code transmitter with illegal-code recovery.
// Optional STATE_PARITY_EN stores a parity bit with the state and adds code_par.
module state_code_sequencer
    import seq_state_pkg::*;
#(
    parameter  int RUN_CYCLES = 8,
    localparam int CNT_W      = $clog2(RUN_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             halt,
    input  logic             stop_ack,
    input  logic             clr_err,
    output logic [2:0]       code,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] run_cnt,
    output logic             illegal_err
`ifdef STATE_PARITY_EN
    ,
    output logic             code_par
`endif
);

    state_t state_q;
    state_t state_d;
    logic   busy_q;
    logic   done_q;
    logic   done_d;
    logic   err_q;
    logic   err_set;
    logic   bad_code;
    logic   bad_par;
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_frz;
    logic   cnt_tc;

    assign bad_code = (state_q >= ILLEGAL_MIN);

`ifdef STATE_PARITY_EN
    logic par_q;
    logic code_par_q;
    assign bad_par  = (par_q != even_par(state_q));
    assign code_par = code_par_q;
`else
    assign bad_par = 1'b0;
`endif

    run_timer #(
        .RUN_CYCLES (RUN_CYCLES),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .frz (cnt_frz),
        .cnt (run_cnt),
        .tc  (cnt_tc)
    );

    // Next-state, timer control and error detection.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_set = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        cnt_frz = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go && !halt) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_clr = 1'b1;
                state_d = halt ? STOP : RUN;
            end
            RUN: begin
                cnt_en  = 1'b1;
                cnt_frz = halt;
                if (halt || cnt_tc) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (stop_ack) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                err_set = 1'b1;
                cnt_clr = 1'b1;
            end
        endcase
        // A corrupted state (bad code or bad parity) always recovers.
        if (bad_code || bad_par) begin
            state_d = IDLE;
            err_set = 1'b1;
            done_d  = 1'b0;
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
        end
    end

    // State register with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    // Sticky illegal flag; a new detection beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (clr_err) begin
            err_q <= 1'b0;
        end
    end

`ifdef STATE_PARITY_EN
    // Stored parity travels with the state; code_par mirrors the code.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q      <= 1'b0;
            code_par_q <= 1'b0;
        end else begin
            par_q      <= even_par(state_d);
            code_par_q <= even_par(state_d);
        end
    end
`endif

    assign code        = state_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign illegal_err = err_q;

endmodule

// File: tb/tb_state_code_sequencer.sv
// Directed self-checking bench for state_code_sequencer.
// Covers RUN_CYCLES=8 and RUN_CYCLES=1 instances.
module tb_state_code_sequencer;
    import seq_state_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go = 1'b0;
    logic       go1 = 1'b0;
    logic       halt = 1'b0;
    logic       stop_ack = 1'b0;
    logic       ack1 = 1'b0;
    logic       clr_err = 1'b0;
    logic [2:0] code;
    logic       busy;
    logic       done;
    logic [3:0] run_cnt;
    logic       illegal_err;
    logic [2:0] code1;
    logic       busy1;
    logic       done1;
    logic [0:0] run_cnt1;
    logic       illegal_err1;
`ifdef STATE_PARITY_EN
    logic       code_par;
    logic       code_par1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    state_code_sequencer #(.RUN_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .halt        (halt),
        .stop_ack    (stop_ack),
        .clr_err     (clr_err),
        .code        (code),
        .busy        (busy),
        .done        (done),
        .run_cnt     (run_cnt),
        .illegal_err (illegal_err)
`ifdef STATE_PARITY_EN
        ,
        .code_par    (code_par)
`endif
    );

    state_code_sequencer #(.RUN_CYCLES(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .go          (go1),
        .halt        (halt),
        .stop_ack    (ack1),
        .clr_err     (clr_err),
        .code        (code1),
        .busy        (busy1),
        .done        (done1),
        .run_cnt     (run_cnt1),
        .illegal_err (illegal_err1)
`ifdef STATE_PARITY_EN
        ,
        .code_par    (code_par1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
`ifdef STATE_PARITY_EN
        chk("code_par", 32'(code_par), 32'(^code));
        chk("code_par1", 32'(code_par1), 32'(^code1));
`endif
    endtask

    task automatic chk_main(input string tag, input logic [2:0] c,
                            input logic b, input logic d,
                            input logic [3:0] n);
        chk({tag, ".code"}, 32'(code), 32'(c));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".run_cnt"}, 32'(run_cnt), 32'(n));
    endtask

    task automatic ack_stop();
        stop_ack = 1'b1;
        tick();
        stop_ack = 1'b0;
        chk_main("ack", 3'd0, 1'b0, 1'b1, 4'd0);
        tick();
        chk_main("ack_after", 3'd0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        go  = 1'b1;
        tick();
        rst = 1'b0;
        go  = 1'b0;
        chk_main("reset", 3'd0, 1'b0, 1'b0, 4'd0);
        chk("reset.err", 32'(illegal_err), 32'd0);
        chk("reset1.code", 32'(code1), 32'd0);
        tick();

        // Normal run
        go = 1'b1;
        tick();
        go = 1'b0;
        chk_main("start", 3'd1, 1'b1, 1'b0, 4'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk_main($sformatf("run%0d", i), 3'd2, 1'b1, 1'b0, 4'(i));
            tick();
        end
        chk_main("stop", 3'd3, 1'b1, 1'b0, 4'd7);
        tick();
        tick();
        chk_main("stop_wait", 3'd3, 1'b1, 1'b0, 4'd7);
        ack_stop();

        // go and halt together in IDLE: halt wins
        go   = 1'b1;
        halt = 1'b1;
        tick();
        chk_main("go_halt", 3'd0, 1'b0, 1'b0, 4'd0);
        go   = 1'b0;
        halt = 1'b0;
        tick();
        chk_main("go_halt2", 3'd0, 1'b0, 1'b0, 4'd0);

        // Abort at run_cnt=2
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        tick();
        chk_main("abort_pre", 3'd2, 1'b1, 1'b0, 4'd2);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk_main("abort", 3'd3, 1'b1, 1'b0, 4'd2);
        tick();
        chk_main("abort_frz", 3'd3, 1'b1, 1'b0, 4'd2);

        // Long STOP hold with ignored go/halt pulses
        for (int i = 0; i < 20; i++) begin
            go   = (i % 5 == 2);
            halt = (i == 7);
            tick();
            chk_main($sformatf("hold%0d", i), 3'd3, 1'b1, 1'b0, 4'd2);
        end
        go   = 1'b0;
        halt = 1'b0;
        ack_stop();

        // halt in START goes straight to STOP
        go = 1'b1;
        tick();
        go   = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk_main("start_halt", 3'd3, 1'b1, 1'b0, 4'd0);
        ack_stop();

        // stop_ack outside STOP is ignored
        stop_ack = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        stop_ack = 1'b0;
        chk_main("ack_run", 3'd2, 1'b1, 1'b0, 4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Illegal code recovery
        force dut.state_q = state_t'(3'b101);
        tick();
        chk("ill.err_set", 32'(illegal_err), 32'd1);
        release dut.state_q;
        tick();
        chk_main("ill", 3'd0, 1'b0, 1'b0, 4'd0);
        chk("ill.err", 32'(illegal_err), 32'd1);
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk_main("ill_run", 3'd3, 1'b1, 1'b0, 4'd7);
        ack_stop();
        chk("ill.sticky", 32'(illegal_err), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ill.clr", 32'(illegal_err), 32'd0);

        // Set beats clear in the same cycle
        clr_err = 1'b1;
        force dut.state_q = state_t'(3'b110);
        tick();
        release dut.state_q;
        chk("ill.set_win", 32'(illegal_err), 32'd1);
        tick();
        tick();
        clr_err = 1'b0;
        chk("ill.clr2", 32'(illegal_err), 32'd0);
        chk("ill.code2", 32'(code), 32'd0);

        // Reset mid-RUN at run_cnt=5
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk_main("mid_pre", 3'd2, 1'b1, 1'b0, 4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_main("mid_rst", 3'd0, 1'b0, 1'b0, 4'd0);
        tick();
        chk_main("mid_rst2", 3'd0, 1'b0, 1'b0, 4'd0);

        // RUN_CYCLES=1 instance
        go1 = 1'b1;
        tick();
        go1 = 1'b0;
        chk("rc1.start", 32'(code1), 32'd1);
        tick();
        chk("rc1.run", 32'(code1), 32'd2);
        chk("rc1.cnt", 32'(run_cnt1), 32'd0);
        tick();
        chk("rc1.stop", 32'(code1), 32'd3);
        chk("rc1.cnt2", 32'(run_cnt1), 32'd0);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk("rc1.idle", 32'(code1), 32'd0);
        chk("rc1.done", 32'(done1), 32'd1);
        tick();
        chk("rc1.done0", 32'(done1), 32'd0);

`ifdef STATE_PARITY_EN
        // Corrupted parity bit during RUN
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        force dut.par_q = ~dut.par_q;
        tick();
        release dut.par_q;
        chk("par.code", 32'(code), 32'd0);
        chk("par.err", 32'(illegal_err), 32'd1);
        tick();
        chk("par.code2", 32'(code), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("par.clr", 32'(illegal_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
